// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: command sequencer driving a JK flip-flop bank's J/K vectors on falling edges.
module jk_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             aborted
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [2:0] OP_CLEAR = 3'd1, OP_LOAD = 3'd2, OP_UP = 3'd3,
                         OP_DOWN = 3'd4, OP_SHIFT = 3'd5, OP_TOGGLE = 3'd6;
  state_t state, state_nx;
  logic [2:0] op;
  logic [WIDTH-1:0] data, t_up, t_dn, sh;
  logic [CNT_W-1:0] rem, rem_init;
  logic accept;
  assign accept = cmd_valid && cmd_ready;
  assign rem_init = (cmd_op == OP_CLEAR || cmd_op == OP_LOAD) ? CNT_W'(1) :
                    (cmd_op >= OP_UP && cmd_op <= OP_TOGGLE) ? cmd_len : '0;
  always_ff @(negedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= '0;
      data    <= '0;
      rem     <= '0;
      aborted <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op      <= cmd_op;
        data    <= cmd_data;
        rem     <= rem_init;
        aborted <= 1'b0;
      end else if (state == RUN) begin
        rem <= (rem != '0) ? rem - 1'b1 : rem;
        if (abort) aborted <= 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ((rem_init == '0) ? FIN : RUN) : IDLE;
      RUN:     state_nx = (abort || rem <= CNT_W'(1)) ? FIN : RUN;
      default: state_nx = IDLE;
    endcase
  end
  // Ripple enables: a bit toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    t_up = '0;
    t_dn = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q_in[i-1];
      t_dn[i] = t_dn[i-1] & ~q_in[i-1];
    end
    sh = {q_in[WIDTH-2:0], 1'b0};
  end
  always_comb begin
    j_out = '0;
    k_out = '0;
    if (state == RUN && !rst) begin
      j_out = (op == OP_LOAD) ? data : (op == OP_UP) ? t_up : (op == OP_DOWN) ? t_dn :
              (op == OP_SHIFT) ? sh : (op == OP_TOGGLE) ? '1 : '0;
      k_out = (op == OP_CLEAR) ? '1 : (op == OP_LOAD) ? ~data : (op == OP_UP) ? t_up :
              (op == OP_DOWN) ? t_dn : (op == OP_SHIFT) ? ~sh : (op == OP_TOGGLE) ? '1 : '0;
    end
    cmd_ready = !rst && state == IDLE;
    busy      = !rst && state != IDLE;
    done      = !rst && state == FIN;
  end
endmodule

// File: doc/jk_seq_ctrl.md
Name: jk_seq_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit bank of JK flip-flops (jkff instances sharing clk/rst).
- Accepts one command at a time over a valid/ready handshake: clear, load, count up, count down, shift, or toggle.
- Drives the bank's J/K vectors from its own state plus the bank's Q feedback for the commanded number of clock edges, then pulses done.

Parameters:
- WIDTH, 4, number of JK flip-flops in the controlled bank.
- CNT_W, 8, width of the command length field.

Ports:
- clk  input  1  clock; all state updates on the falling edge, matching the JK bank.
- rst  input  1  synchronous active-high reset; same net as the bank's rst.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  opcode: 000 NOP, 001 CLEAR, 010 LOAD, 011 UP, 100 DOWN, 101 SHIFT, 110 TOGGLE, 111 reserved (treated as NOP).
- cmd_data  input  WIDTH  LOAD value.
- cmd_len  input  CNT_W  active edges for UP/DOWN/SHIFT/TOGGLE.
- abort  input  1  terminate a running command.
- q_in  input  WIDTH  Q feedback from the JK bank.
- j_out  output  WIDTH  J vector to the bank.
- k_out  output  WIDTH  K vector to the bank.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  last command ended by abort; valid while done=1, held until next accept.

Behaviour:
- Clocking and reset
  - All registers update on the falling edge of clk.
  - While rst=1: j_out=k_out=0, cmd_ready=0, busy=0, done=0.
  - At the first falling edge with rst=1: state=IDLE and all latched fields, remaining counter and aborted are cleared.
  - A reset during RUN abandons the command with no done pulse.
- States
  - IDLE: cmd_ready=1, j=k=0.
  - RUN: j/k driven per the latched op.
  - DONE: one cycle; done=1, j=k=0, cmd_ready=0.
  - DONE always returns to IDLE.
- Accept
  - A command is accepted at a falling edge with cmd_valid=1 and cmd_ready=1.
  - On accept, latch op, data and len; clear aborted.
  - remaining is set to 1 for CLEAR and LOAD, and to cmd_len for UP/DOWN/SHIFT/TOGGLE.
  - If remaining would be 0 (multi-cycle op with cmd_len=0, NOP, or reserved): go straight to DONE; j/k stay 0.
  - Otherwise go to RUN.
  - cmd_valid while busy is ignored; no queueing.
- RUN
  - Each falling edge decrements remaining.
  - At the edge where remaining==1, go to DONE. The bank has then taken exactly len updates.
  - Latency from accept edge to the done-high cycle: len+1 edges (2 for CLEAR/LOAD).
- j/k generation (combinational from latched op and q_in, during RUN only)
  - CLEAR: j=0, k=all ones.
  - LOAD: j=data, k=~data.
  - UP: t[i] = AND of q_in[i-1:0] (t[0]=1); j=k=t. Wraps all-ones to zero.
  - DOWN: t[i] = NOR of q_in[i-1:0] (t[0]=1); j=k=t. Wraps zero to all-ones.
  - SHIFT: d[i]=q_in[i-1], d[0]=0; j=d, k=~d. Shifts left with zero fill.
  - TOGGLE: j=k=all ones.
- Abort
  - abort=1 at a falling edge in RUN: go to DONE and set aborted=1.
  - j/k remain active for that edge, so the bank still takes the update at that edge.
  - abort is ignored in IDLE and DONE.
- Simultaneous events
  - rst has priority over everything.
  - abort has priority over normal completion; if both happen at the same edge, aborted=1.
- Width rules
  - remaining is CNT_W bits and never underflows.
  - Up to 2^CNT_W-1 steps per command.

Test Plan:
- Reset: rst=1 for 2 falling edges, then 0 -> during rst j=k=0000, cmd_ready=0, busy=0; bank q=0000; cmd_ready=1 after the first edge with rst=0.
- LOAD 1010 -> in RUN j=1010, k=0101; q=1010 after 1 edge; done=1 the next cycle, aborted=0; cmd_ready=1 after that.
- UP from 1110, len=5 -> q sequence 1111, 0000, 0001, 0010, 0011; done asserts the cycle after the 5th edge. DOWN from 0001, len=3 -> 0000, 1111, 1110.
- SHIFT from 0111, len=2 -> 1110, then 1100; done next cycle; a cmd_valid with LOAD 0101 issued while busy is ignored (q stays 1100).
- TOGGLE from 0000, len=10, abort asserted at the 3rd RUN edge -> q: 1111, 0000, 1111; done=1 and aborted=1 next cycle.
- UP with len=0 from 0110 -> no q change, done the cycle after accept. NOP -> same. rst asserted mid-UP (len=8, after 2 edges) -> q=0000, no done pulse, IDLE.
